key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 190 +++++++++++++++++++
 tb/tb_key_conditioner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
//
// Conditions three raw, active-low push keys into clean, single-cycle event
// pulses for the front-panel controller. Each key is synchronized into the
// clk_50 domain and then debounced. A press produces one pulse. The up and
// down keys also auto-repeat while they are held.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change
//   REPEAT_DELAY     held cycles before the first auto-repeat pulse
//   REPEAT_RATE      cycles between later auto-repeat pulses
//
// Ports
//   clk_50      in   system clock, rising edge
//   rst         in   synchronous, active-high reset
//   key0        in   raw mode key, active-low, asynchronous
//   key1        in   raw up key, active-low, asynchronous
//   key2        in   raw down key, active-low, asynchronous
//   mode_pulse  out  one cycle per accepted key0 press (never repeats)
//   up_pulse    out  one cycle per key1 press or key1 auto-repeat
//   down_pulse  out  one cycle per key2 press or key2 auto-repeat
//   held        out  debounced pressed level, active-high, bit i = key i
// ---------------------------------------------------------------------------
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       key0,
  input  logic       key1,
  input  logic       key2,
  output logic       mode_pulse,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic [2:0] held
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

  logic [2:0] raw_keys;
  assign raw_keys = {key2, key1, key0};

  // Synchronizer stages hold the raw (active-low) key level.
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  // Debounced pressed level and its one-cycle-delayed copy for edge detection.
  logic [2:0]       held_q, held_d;
  logic [2:0]       held_dly_q, held_dly_d;
  logic [DB_W-1:0]  db_cnt_q [3];
  logic [DB_W-1:0]  db_cnt_d [3];
  logic [2:0]       press;

  // Index 0 serves key1 (up), index 1 serves key2 (down).
  rpt_state_e       state_q   [2];
  rpt_state_e       state_d   [2];
  logic [RPT_W-1:0] rpt_cnt_q [2];
  logic [RPT_W-1:0] rpt_cnt_d [2];
  logic [1:0]       rpt_fire;
  logic             both_held;

  logic             mode_pulse_q, mode_pulse_d;
  logic             up_pulse_q, up_pulse_d;
  logic             down_pulse_q, down_pulse_d;

  // Synchronize and debounce.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path leaves it unassigned and infers a latch.
    sync1_d    = raw_keys;
    sync2_d    = sync1_q;
    held_d     = held_q;
    held_dly_d = held_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      // sync2_q is active-low, so inverting it gives the pressed level.
      if (~sync2_q[i] != held_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          held_d[i] = ~held_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    // A press is seen in the cycle after held rises. Releases give no pulse.
    press = held_q & ~held_dly_q;
  end

  // Auto-repeat for the up and down keys.
  always_comb begin
    // When both keys are held together, both stay silent until a fresh press.
    both_held = held_d[1] & held_d[2];
    rpt_fire  = '0;
    for (int j = 0; j < 2; j++) begin
      state_d[j]   = state_q[j];
      rpt_cnt_d[j] = rpt_cnt_q[j];
      // A release aborts on the same edge. The fire logic below is skipped,
      // so no pulse goes out on that edge.
      if (!held_d[j+1] || both_held) begin
        state_d[j]   = IDLE;
        rpt_cnt_d[j] = '0;
      end else begin
        case (state_q[j])
          IDLE: begin
            if (press[j+1]) begin
              state_d[j]   = DELAY;
              rpt_cnt_d[j] = '0;
            end
          end
          DELAY: begin
            if (rpt_cnt_q[j] == DELAY_LAST) begin
              state_d[j]   = REPEAT;
              rpt_cnt_d[j] = '0;
              rpt_fire[j]  = 1'b1;
            end else begin
              rpt_cnt_d[j] = rpt_cnt_q[j] + 1'b1;
            end
          end
          REPEAT: begin
            if (rpt_cnt_q[j] == RATE_LAST) begin
              rpt_cnt_d[j] = '0;
              rpt_fire[j]  = 1'b1;
            end else begin
              rpt_cnt_d[j] = rpt_cnt_q[j] + 1'b1;
            end
          end
          default: begin
            state_d[j]   = IDLE;
            rpt_cnt_d[j] = '0;
          end
        endcase
      end
    end

    mode_pulse_d = press[0];
    up_pulse_d   = press[1] | rpt_fire[0];
    down_pulse_d = press[2] | rpt_fire[1];
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      // Reset to "released" so that a key held through reset reads as a new press.
      sync1_q      <= '1;
      sync2_q      <= '1;
      held_q       <= '0;
      held_dly_q   <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      for (int j = 0; j < 2; j++) begin
        state_q[j]   <= IDLE;
        rpt_cnt_q[j] <= '0;
      end
      mode_pulse_q <= 1'b0;
      up_pulse_q   <= 1'b0;
      down_pulse_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so that every flop samples pre-edge values.
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      held_q       <= held_d;
      held_dly_q   <= held_dly_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int j = 0; j < 2; j++) begin
        state_q[j]   <= state_d[j];
        rpt_cnt_q[j] <= rpt_cnt_d[j];
      end
      mode_pulse_q <= mode_pulse_d;
      up_pulse_q   <= up_pulse_d;
      down_pulse_q <= down_pulse_d;
    end
  end

  assign mode_pulse = mode_pulse_q;
  assign up_pulse   = up_pulse_q;
  assign down_pulse = down_pulse_q;
  assign held       = held_q;

endmodule

// File: tb/tb_key_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_conditioner
//
// Directed bench for key_conditioner, using DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10 and REPEAT_RATE=3.
//
// Timing convention: a key is driven 1 ns after rising edge 0, which makes it
// cycle 0. Sample n is taken 1 ns after rising edge n. With this convention a
// clean press gives held at n=6 and the press pulse at n=7.
//
// The observed vector is {mode_pulse, up_pulse, down_pulse, held[2:0]}.
// ---------------------------------------------------------------------------
module tb_key_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic       clk_50 = 1'b0;
  logic       rst    = 1'b1;
  logic       key0   = 1'b1;
  logic       key1   = 1'b1;
  logic       key2   = 1'b1;
  logic       mode_pulse, up_pulse, down_pulse;
  logic [2:0] held;

  int checks = 0;
  int errors = 0;

  key_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk_50     (clk_50),
    .rst        (rst),
    .key0       (key0),
    .key1       (key1),
    .key2       (key2),
    .mode_pulse (mode_pulse),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .held       (held)
  );

  always #5 clk_50 = ~clk_50;

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic do_reset();
    key0 = 1'b1;
    key1 = 1'b1;
    key2 = 1'b1;
    rst  = 1'b1;
    step();
    step();
    rst  = 1'b0;
  endtask

  // All outputs must read 0 while reset is applied, even with the keys pressed.
  task automatic test_reset();
    key0 = 1'b0;
    key1 = 1'b0;
    key2 = 1'b0;
    rst  = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      checks++;
      if ({mode_pulse, up_pulse, down_pulse, held} !== 6'b000000) begin
        errors++;
        $display("FAIL reset n=%0d: got %b expected %b", n,
                 {mode_pulse, up_pulse, down_pulse, held}, 6'b000000);
      end
    end
    do_reset();
  endtask

  // key0 is held for 40 cycles: one mode pulse, no repeat.
  task automatic test_mode_key();
    logic [5:0] exp;
    do_reset();
    key0 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      step();
      exp = {(n == 7), 1'b0, 1'b0, 2'b00, (n >= 6 && n < 46)};
      checks++;
      if ({mode_pulse, up_pulse, down_pulse, held} !== exp) begin
        errors++;
        $display("FAIL mode_key n=%0d: got %b expected %b", n,
                 {mode_pulse, up_pulse, down_pulse, held}, exp);
      end
      if (n == 40) key0 = 1'b1;
    end
  endtask

  // Five bursts of 3 cycles low and 2 cycles high. Each burst is too short to
  // be accepted.
  task automatic test_glitch();
    do_reset();
    for (int n = 0; n < 40; n++) begin
      key1 = (n < 25 && (n % 5) < 3) ? 1'b0 : 1'b1;
      step();
      checks++;
      if ({mode_pulse, up_pulse, down_pulse, held} !== 6'b000000) begin
        errors++;
        $display("FAIL glitch n=%0d: got %b expected %b", n + 1,
                 {mode_pulse, up_pulse, down_pulse, held}, 6'b000000);
      end
    end
  endtask

  // key2 is low for cycles 0..29. The debounced release lands at n=36, so
  // repeats continue at 32 and 35 and stop after that.
  task automatic test_repeat();
    logic [5:0] exp;
    logic       dn;
    do_reset();
    key2 = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      step();
      dn  = n inside {7, 17, 20, 23, 26, 29, 32, 35};
      exp = {1'b0, 1'b0, dn, (n >= 6 && n < 36), 2'b00};
      checks++;
      if ({mode_pulse, up_pulse, down_pulse, held} !== exp) begin
        errors++;
        $display("FAIL repeat n=%0d: got %b expected %b", n,
                 {mode_pulse, up_pulse, down_pulse, held}, exp);
      end
      if (n == 30) key2 = 1'b1;
    end
  endtask

  // key1 and key2 are pressed together: both press pulses, no repeats.
  task automatic test_simultaneous();
    logic [5:0] exp;
    logic       h;
    do_reset();
    key1 = 1'b0;
    key2 = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      step();
      h   = (n >= 6 && n < 36);
      exp = {1'b0, (n == 7), (n == 7), h, h, 1'b0};
      checks++;
      if ({mode_pulse, up_pulse, down_pulse, held} !== exp) begin
        errors++;
        $display("FAIL simultaneous n=%0d: got %b expected %b", n,
                 {mode_pulse, up_pulse, down_pulse, held}, exp);
      end
      if (n == 30) begin
        key1 = 1'b1;
        key2 = 1'b1;
      end
    end
  endtask

  // After an overlapping hold, key1 is released first. key2 stays held but
  // must not start repeating without a fresh press.
  task automatic test_overlap_release();
    logic [5:0] exp;
    do_reset();
    key1 = 1'b0;
    key2 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      step();
      exp = {1'b0, (n == 7), (n == 7), (n >= 6 && n < 51), (n >= 6 && n < 21), 1'b0};
      checks++;
      if ({mode_pulse, up_pulse, down_pulse, held} !== exp) begin
        errors++;
        $display("FAIL overlap_release n=%0d: got %b expected %b", n,
                 {mode_pulse, up_pulse, down_pulse, held}, exp);
      end
      if (n == 15) key1 = 1'b1;
      if (n == 45) key2 = 1'b1;
    end
  endtask

  // Reset is applied during key1's DELAY phase (cycle 12, taking effect at
  // edge 13). The pending repeat at 17 is aborted. Because key1 is still low,
  // it re-presses at 13+7=20 and then repeats at 30, 33, 36 and 39.
  task automatic test_reset_mid_repeat();
    logic [5:0] exp;
    logic       up;
    do_reset();
    key1 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      step();
      up  = n inside {7, 20, 30, 33, 36, 39};
      exp = {1'b0, up, 1'b0, 1'b0, ((n >= 6 && n < 13) || n >= 19), 1'b0};
      checks++;
      if ({mode_pulse, up_pulse, down_pulse, held} !== exp) begin
        errors++;
        $display("FAIL reset_mid_repeat n=%0d: got %b expected %b", n,
                 {mode_pulse, up_pulse, down_pulse, held}, exp);
      end
      if (n == 12) rst = 1'b1;
      if (n == 13) rst = 1'b0;
    end
    key1 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mode_key();
    test_glitch();
    test_repeat();
    test_simultaneous();
    test_overlap_release();
    test_reset_mid_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
